// File: rtl/queue_pkg.sv
// Shared types and helpers for the fetch/decode unit stream queues.
// Pointer arithmetic here avoids % so non-power-of-two depths stay cheap.
package queue_pkg;

    localparam int UNIT_W_DFLT = 8;

    typedef logic [UNIT_W_DFLT-1:0] unit_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // ptr < depth and inc <= depth, so one conditional subtract suffices
    function automatic int wrap_add(input int ptr, input int inc,
                                    input int depth);
        int sum;
        sum = ptr + inc;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/unit_window_read.sv
// Head window of a circular unit store, oldest unit in the MSBs.
// Slots at or beyond the live count read as zero.
module unit_window_read
    import queue_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int OUT_UNITS = 8,
    parameter int UNIT_W    = 8,
    parameter int CW        = cnt_w(DEPTH),
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [UNIT_W-1:0]           mem [DEPTH],
    input  logic [AW-1:0]               head,
    input  logic [CW-1:0]               cnt,
    output logic [OUT_UNITS*UNIT_W-1:0] out_data
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < OUT_UNITS; i++) begin
            if (i < int'(cnt)) begin
                out_data[(OUT_UNITS-1-i)*UNIT_W +: UNIT_W] =
                    mem[AW'(wrap_add(int'(head), i, DEPTH))];
            end
        end
    end

endmodule

// File: rtl/unit_stream_queue.sv
// Circular byte-unit queue between fetch and decode with per-cycle
// variable enqueue/dequeue widths, flush, and sticky error flags.
module unit_stream_queue
    import queue_pkg::*;
#(
    parameter int UNIT_W    = 8,
    parameter int IN_UNITS  = 8,
    parameter int OUT_UNITS = 8,
    parameter int DEPTH     = 32,
    parameter int AFULL_LVL = DEPTH - IN_UNITS,
    parameter int CW        = cnt_w(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        en_queue,
    input  logic [CW-1:0]               in_count,
    input  logic [IN_UNITS*UNIT_W-1:0]  in_data,
    output logic                        in_accept,
    input  logic                        de_queue,
    input  logic [CW-1:0]               out_count,
    output logic                        out_accept,
    output logic [OUT_UNITS*UNIT_W-1:0] out_data,
    output logic [CW-1:0]               used_count,
    output logic [CW-1:0]               free_count,
    output logic                        almost_full,
    output logic                        ovf_err,
    output logic                        unf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [UNIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     add_n;
    logic [CW-1:0]     sub_n;

    assign used_count  = cnt;
    assign free_count  = CW'(DEPTH) - cnt;
    assign almost_full = int'(cnt) >= AFULL_LVL;

    assign in_accept = en_queue && !flush &&
                       (int'(in_count) <= IN_UNITS) &&
                       (in_count <= free_count);

    assign out_accept = de_queue && !flush &&
                        (int'(out_count) <= OUT_UNITS) &&
                        (out_count <= cnt);

    assign add_n = in_accept  ? in_count  : '0;
    assign sub_n = out_accept ? out_count : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (in_accept)
                tail <= AW'(wrap_add(int'(tail), int'(in_count), DEPTH));
            if (out_accept)
                head <= AW'(wrap_add(int'(head), int'(out_count), DEPTH));
            cnt <= cnt + add_n - sub_n;
            if (en_queue && !in_accept) ovf_err <= 1'b1;
            if (de_queue && !out_accept) unf_err <= 1'b1;
        end
    end

    // Storage is deliberately not reset; the window masks stale slots.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            for (int i = 0; i < IN_UNITS; i++) begin
                if (i < int'(in_count)) begin
                    mem[AW'(wrap_add(int'(tail), i, DEPTH))] <=
                        in_data[(IN_UNITS-1-i)*UNIT_W +: UNIT_W];
                end
            end
        end
    end

    unit_window_read #(
        .DEPTH     (DEPTH),
        .OUT_UNITS (OUT_UNITS),
        .UNIT_W    (UNIT_W),
        .CW        (CW),
        .AW        (AW)
    ) u_window (
        .mem      (mem),
        .head     (head),
        .cnt      (cnt),
        .out_data (out_data)
    );

endmodule

// File: doc/unit_stream_queue.md
# unit_stream_queue

- Parametrised circular queue for variable-length instruction-byte streams between fetch and decode.
- Per cycle it accepts 0..IN_UNITS units and releases 0..OUT_UNITS units, each unit UNIT_W bits.
- Adds the following:
  - explicit accept/reject of each request;
  - zero-masked output window;
  - synchronous flush, for branch redirect;
  - almost-full threshold;
  - sticky overflow/underflow error flags.

## Interface
Parameters:
- UNIT_W, 8: bits per unit.
- IN_UNITS, 8: max units enqueued per cycle.
- OUT_UNITS, 8: max units dequeued per cycle; also the width of the output window.
- DEPTH, 32: storage capacity in units. Any integer ≥ max(IN_UNITS, OUT_UNITS); all DEPTH slots are usable.
- AFULL_LVL, DEPTH-IN_UNITS: almost_full asserts when used_count ≥ AFULL_LVL.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; has priority over everything else.
- en_queue  in  1  enqueue request.
- in_count  in  CW  units to enqueue, 0..IN_UNITS. CW = $clog2(DEPTH+1).
- in_data  in  IN_UNITS*UNIT_W  unit 0 in the MSBs; units ≥ in_count are ignored.
- in_accept  out  1  combinational; enqueue takes effect this edge.
- de_queue  in  1  dequeue request.
- out_count  in  CW  units to dequeue, 0..OUT_UNITS.
- out_accept  out  1  combinational; dequeue takes effect this edge.
- out_data  out  OUT_UNITS*UNIT_W  head window, unit 0 = oldest in the MSBs.
- used_count  out  CW  units held.
- free_count  out  CW  DEPTH − used_count.
- almost_full  out  1  used_count ≥ AFULL_LVL.
- ovf_err  out  1  sticky error flag.
- unf_err  out  1  sticky error flag.

## Operation
State:
- head, tail: 0..DEPTH−1.
- cnt: 0..DEPTH.
- storage array mem[DEPTH] of units.

Acceptance (evaluated against pre-edge state only):
- in_accept = en_queue & (in_count ≤ IN_UNITS) & (in_count ≤ free_count) & !flush.
- out_accept = de_queue & (out_count ≤ OUT_UNITS) & (out_count ≤ used_count) & !flush.
- Enqueue and dequeue are evaluated independently. Enqueue while full with a simultaneous dequeue is rejected.

On accepted enqueue:
- mem[(tail+i) mod DEPTH] ← in unit i, for i < in_count.
- tail ← (tail+in_count) mod DEPTH.

On accepted dequeue:
- head ← (head+out_count) mod DEPTH.

Count update:
- cnt ← cnt + acc_in·in_count − acc_out·out_count.
- Result is always within 0..DEPTH.

Output window:
- out_data unit i = mem[(head+i) mod DEPTH] for i < cnt.
- out_data unit i = 0 for i ≥ cnt.

Rejected requests:
- A rejected en_queue (!flush) sets ovf_err.
- A rejected de_queue (!flush) sets unf_err.
- Neither changes the pointers or mem.
- The flags clear only on reset.

Zero counts:
- A request with count 0 is accepted and is a no-op.

Flush:
- head, tail, cnt ← 0 next edge.
- mem contents retained but unreachable.
- Error flags unchanged.

Reset (reset_n low, immediately, asynchronous):
- head = tail = cnt = 0.
- ovf_err = unf_err = 0.
- Outputs: used_count 0, free_count DEPTH, out_data 0, almost_full 0 (given AFULL_LVL > 0), in_accept/out_accept follow their equations.
- mem is not reset.

## Timing
- Accept signals are combinational from inputs and current state, with no internal stall cycle.
- Enqueued units are visible on out_data and used_count the cycle after the edge.
- No same-cycle bypass from in_data to out_data.
- Dequeue removes units at the edge; the next window appears in the following cycle.
- Wrap-around, for both write and read windows, costs no extra cycle; indices are computed mod DEPTH for non-power-of-two depths.
- Mid-operation reset overrides everything asynchronously. Deassertion is synchronised externally.

## Structure
- Shared package queue_pkg:
  - count-width function cnt_w(depth);
  - unit typedef unit_t (logic [UNIT_W-1:0]);
  - function wrap_add(ptr, inc, depth), which avoids the % operator.
- Sub-module unit_window_read(DEPTH, OUT_UNITS, UNIT_W):
  - inputs: mem, head, cnt;
  - output: out_data, zero-masked.
  - Reused later by the decode-side queue.
- Top module holds pointers, acceptance logic, write loop and flags.

## Test plan
- Reset, then enqueue 8 units 0x01..0x08 -> next cycle used_count=8, free_count=24, out_data = 01 02 … 08.
- DEPTH=32, fill to 28, dequeue to head=28, then enqueue 8 units 0xA0..0xA7 -> write wraps to slots 28..31,0..3; after dequeuing 28 the window reads A0..A7 contiguously.
- Full queue (32), en_queue in_count=1 with simultaneous de_queue out_count=4 -> in_accept=0, out_accept=1, ovf_err=1, used_count=28.
- used_count=3, de_queue out_count=5 -> out_accept=0, unf_err=1, state unchanged; out_data units 3..7 read 0.
- flush with en_queue and de_queue active at used_count=20 -> both accepts 0, no error flags set, used_count=0 next cycle.
- reset_n pulsed low mid-cycle at used_count=17 with ovf_err=1 -> used_count=0, free_count=32, ovf_err=0 before the next clk edge.
